// File: rtl/execute_hazard_scheduler.sv
// Issue-side RAW/WAW hazard scheduler with a shift-register scoreboard and forwarding selects.
// Optional stall performance counter enabled by defining HAZARD_PERF_CNT_EN.
module execute_hazard_scheduler #(
   parameter int DEPTH = 4,
   parameter int LAT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             issue_valid,
   input  logic [6:0]       issue_ra,
   input  logic [6:0]       issue_rb,
   input  logic [6:0]       issue_rc,
   input  logic [2:0]       issue_use,
   input  logic [6:0]       issue_rt,
   input  logic             issue_wr,
   input  logic [LAT_W-1:0] issue_lat,
   input  logic             flush,
   output logic             stall,
   output logic             issue_fire,
   output logic [1:0]       ReadData1Sel,
   output logic [1:0]       ReadData2Sel,
   output logic [1:0]       ReadDataCSel,
   output logic [15:0]      stall_cycles
);

   // Extra bits so age (up to DEPTH+1) and age+lat sums never wrap
   localparam int AW = LAT_W + 2;

   logic [DEPTH:0]   vld_q, vld_d;
   logic [6:0]       rt_q  [DEPTH+1];
   logic [6:0]       rt_d  [DEPTH+1];
   logic [LAT_W-1:0] lat_q [DEPTH+1];
   logic [LAT_W-1:0] lat_d [DEPTH+1];

   logic [AW-1:0] lat_new;
   logic [AW-1:0] age;
   logic [AW-1:0] slot_lat;
   logic [6:0]    src [3];
   logic [2:0]    haz;
   logic [1:0]    sel [3];
   logic          waw;

   always_comb begin
      if (issue_lat == '0)
         lat_new = AW'(1);
      else if (AW'(issue_lat) > AW'(DEPTH))
         lat_new = AW'(DEPTH);
      else
         lat_new = AW'(issue_lat);
   end

   // Scan oldest to youngest so the youngest matching producer wins
   always_comb begin
      src[0]   = issue_ra;
      src[1]   = issue_rb;
      src[2]   = issue_rc;
      haz      = '0;
      waw      = 1'b0;
      age      = '0;
      slot_lat = '0;
      for (int s = 0; s < 3; s++) begin
         sel[s] = 2'b00;
         for (int k = DEPTH; k >= 0; k--) begin
            if (vld_q[k] && (rt_q[k] == src[s])) begin
               age      = AW'(k + 1);
               slot_lat = AW'(lat_q[k]);
               haz[s]   = (age < slot_lat);
               if (age == slot_lat)
                  sel[s] = 2'b01;
               else if (age == slot_lat + AW'(1))
                  sel[s] = 2'b10;
               else
                  sel[s] = 2'b00;
            end
         end
         if (!issue_use[s]) begin
            haz[s] = 1'b0;
            sel[s] = 2'b00;
         end
      end
      for (int k = 0; k <= DEPTH; k++) begin
         if (issue_wr && vld_q[k] && (rt_q[k] == issue_rt) &&
             (AW'(lat_q[k]) >= AW'(k + 1) + lat_new))
            waw = 1'b1;
      end
   end

   assign stall        = issue_valid & ((|haz) | waw);
   assign issue_fire   = issue_valid & ~stall & ~flush;
   assign ReadData2Sel = issue_fire ? sel[0] : 2'b00;
   assign ReadData1Sel = issue_fire ? sel[1] : 2'b00;
   assign ReadDataCSel = issue_fire ? sel[2] : 2'b00;

   always_comb begin
      vld_d    = {vld_q[DEPTH-1:0], issue_fire & issue_wr};
      rt_d[0]  = issue_rt;
      lat_d[0] = lat_new[LAT_W-1:0];
      for (int k = 1; k <= DEPTH; k++) begin
         rt_d[k]  = rt_q[k-1];
         lat_d[k] = lat_q[k-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         vld_q <= '0;
      else
         vld_q <= vld_d;
   end

   // Payload needs no reset; it is qualified by vld_q
   always_ff @(posedge clk) begin
      for (int k = 0; k <= DEPTH; k++) begin
         rt_q[k]  <= rt_d[k];
         lat_q[k] <= lat_d[k];
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (stall && (cnt_q != 16'hFFFF))
         cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign stall_cycles = cnt_q;
`else
   assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_execute_hazard_scheduler.sv
// Directed self-checking bench for execute_hazard_scheduler (DEPTH=4, LAT_W=3).
module tb_execute_hazard_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        issue_valid;
   logic [6:0]  issue_ra, issue_rb, issue_rc, issue_rt;
   logic [2:0]  issue_use;
   logic        issue_wr;
   logic [2:0]  issue_lat;
   logic        flush;
   logic        stall, issue_fire;
   logic [1:0]  ReadData1Sel, ReadData2Sel, ReadDataCSel;
   logic [15:0] stall_cycles;

   int tests = 0;
   int errs  = 0;

   execute_hazard_scheduler #(.DEPTH(4), .LAT_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
      .issue_ra(issue_ra), .issue_rb(issue_rb), .issue_rc(issue_rc),
      .issue_use(issue_use), .issue_rt(issue_rt), .issue_wr(issue_wr),
      .issue_lat(issue_lat), .flush(flush), .stall(stall),
      .issue_fire(issue_fire), .ReadData1Sel(ReadData1Sel),
      .ReadData2Sel(ReadData2Sel), .ReadDataCSel(ReadDataCSel),
      .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [6:0] ra, input logic [6:0] rb,
                        input logic [6:0] rc, input logic [2:0] use_m, input logic [6:0] rt,
                        input logic wr, input logic [2:0] lat, input logic fl);
      issue_valid = v;  issue_ra = ra;  issue_rb = rb;  issue_rc = rc;
      issue_use = use_m; issue_rt = rt; issue_wr = wr;  issue_lat = lat; flush = fl;
   endtask

   task automatic drain();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (6) next_cycle();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(1, 7'($urandom), 7'($urandom), 7'($urandom), 3'($urandom),
            7'($urandom), 1'b1, 3'($urandom), 1'b0);
      repeat (2) next_cycle();
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      do_reset();
      drive(1, 5, 5, 5, 3'b111, 6, 0, 1, 0);
      @(negedge clk);
      tests++;
      if (stall !== 1'b0 || issue_fire !== 1'b1 || ReadData1Sel !== 2'b00 ||
          ReadData2Sel !== 2'b00 || ReadDataCSel !== 2'b00) begin
         errs++;
         $display("FAIL reset_empty stall=%b fire=%b sel1=%b sel2=%b selc=%b exp 0 1 00 00 00",
                  stall, issue_fire, ReadData1Sel, ReadData2Sel, ReadDataCSel);
      end
      tests++;
      if (stall_cycles !== 16'h0000) begin
         errs++;
         $display("FAIL reset_cnt stall_cycles=%h exp 0000", stall_cycles);
      end
      next_cycle();
      drain();
   endtask

   task automatic test_reset_midop();
      drive(1, 0, 0, 0, 0, 20, 1, 4, 0);
      next_cycle();
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      next_cycle();
      rst_n = 1'b1;
      drive(1, 20, 0, 0, 3'b001, 0, 0, 1, 0);
      @(negedge clk);
      tests++;
      if (stall !== 1'b0 || issue_fire !== 1'b1 || ReadData2Sel !== 2'b00) begin
         errs++;
         $display("FAIL reset_midop stall=%b fire=%b sel2=%b exp 0 1 00", stall, issue_fire, ReadData2Sel);
      end
      next_cycle();
      drain();
   endtask

   task automatic test_forward_l1();
      drive(1, 0, 0, 0, 0, 3, 1, 1, 0);
      @(negedge clk);
      tests++;
      if (issue_fire !== 1'b1) begin
         errs++; $display("FAIL fwd_prod fire=%b exp 1", issue_fire);
      end
      next_cycle();
      drive(1, 3, 0, 0, 3'b001, 0, 0, 1, 0);
      @(negedge clk);
      tests++;
      if (stall !== 1'b0 || issue_fire !== 1'b1 || ReadData2Sel !== 2'b01) begin
         errs++;
         $display("FAIL fwd_age1 stall=%b fire=%b sel2=%b exp 0 1 01", stall, issue_fire, ReadData2Sel);
      end
      next_cycle();
      drive(1, 3, 3, 3, 3'b110, 0, 0, 1, 0);
      @(negedge clk);
      tests++;
      if (stall !== 1'b0 || ReadData1Sel !== 2'b10 || ReadDataCSel !== 2'b10 || ReadData2Sel !== 2'b00) begin
         errs++;
         $display("FAIL fwd_age2 stall=%b sel1=%b selc=%b sel2=%b exp 0 10 10 00",
                  stall, ReadData1Sel, ReadDataCSel, ReadData2Sel);
      end
      next_cycle();
      drive(1, 3, 3, 3, 3'b111, 0, 0, 1, 0);
      @(negedge clk);
      tests++;
      if (stall !== 1'b0 || ReadData1Sel !== 2'b00 || ReadDataCSel !== 2'b00 || ReadData2Sel !== 2'b00) begin
         errs++;
         $display("FAIL fwd_age3 stall=%b sel1=%b selc=%b sel2=%b exp 0 00 00 00",
                  stall, ReadData1Sel, ReadDataCSel, ReadData2Sel);
      end
      next_cycle();
      drain();
   endtask

   task automatic test_raw_l3();
      drive(1, 0, 0, 0, 0, 7, 1, 3, 0);
      next_cycle();
      drive(1, 0, 7, 0, 3'b010, 0, 0, 1, 0);
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk);
         tests++;
         if (stall !== 1'b1 || issue_fire !== 1'b0 || ReadData1Sel !== 2'b00) begin
            errs++;
            $display("FAIL raw_stall c%0d stall=%b fire=%b sel1=%b exp 1 0 00", c, stall, issue_fire, ReadData1Sel);
         end
         next_cycle();
      end
      @(negedge clk);
      tests++;
      if (stall !== 1'b0 || issue_fire !== 1'b1 || ReadData1Sel !== 2'b01) begin
         errs++;
         $display("FAIL raw_fire stall=%b fire=%b sel1=%b exp 0 1 01", stall, issue_fire, ReadData1Sel);
      end
      next_cycle();
      drain();
   endtask

   task automatic test_waw();
      drive(1, 0, 0, 0, 0, 9, 1, 4, 0);
      next_cycle();
      drive(1, 0, 0, 0, 0, 9, 1, 1, 0);
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         tests++;
         if (stall !== 1'b1 || issue_fire !== 1'b0) begin
            errs++;
            $display("FAIL waw_stall c%0d stall=%b fire=%b exp 1 0", c, stall, issue_fire);
         end
         next_cycle();
      end
      @(negedge clk);
      tests++;
      if (stall !== 1'b0 || issue_fire !== 1'b1) begin
         errs++;
         $display("FAIL waw_fire stall=%b fire=%b exp 0 1", stall, issue_fire);
      end
      next_cycle();
      drain();
   endtask

   task automatic test_lat_norm();
      drive(1, 0, 0, 0, 0, 4, 1, 0, 0);
      next_cycle();
      drive(1, 4, 0, 0, 3'b001, 0, 0, 1, 0);
      @(negedge clk);
      tests++;
      if (stall !== 1'b0 || ReadData2Sel !== 2'b01) begin
         errs++;
         $display("FAIL lat0_as1 stall=%b sel2=%b exp 0 01", stall, ReadData2Sel);
      end
      next_cycle();
      drain();
      drive(1, 0, 0, 0, 0, 6, 1, 7, 0);
      next_cycle();
      drive(1, 6, 0, 0, 3'b001, 0, 0, 1, 0);
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         tests++;
         if (stall !== 1'b1) begin
            errs++;
            $display("FAIL lat_clamp_stall c%0d stall=%b exp 1", c, stall);
         end
         next_cycle();
      end
      @(negedge clk);
      tests++;
      if (stall !== 1'b0 || issue_fire !== 1'b1 || ReadData2Sel !== 2'b01) begin
         errs++;
         $display("FAIL lat_clamp_fire stall=%b fire=%b sel2=%b exp 0 1 01", stall, issue_fire, ReadData2Sel);
      end
      next_cycle();
      drain();
   endtask

   task automatic test_youngest();
      drive(1, 0, 0, 0, 0, 3, 1, 1, 0);
      next_cycle();
      drive(1, 0, 0, 0, 0, 3, 1, 4, 0);
      @(negedge clk);
      tests++;
      if (issue_fire !== 1'b1) begin
         errs++; $display("FAIL young_prod2 fire=%b exp 1", issue_fire);
      end
      next_cycle();
      drive(1, 3, 0, 0, 3'b001, 0, 0, 1, 0);
      @(negedge clk);
      tests++;
      if (stall !== 1'b1 || ReadData2Sel !== 2'b00) begin
         errs++;
         $display("FAIL young_match stall=%b sel2=%b exp 1 00", stall, ReadData2Sel);
      end
      next_cycle();
      drain();
   endtask

   task automatic test_flush();
      drive(1, 0, 0, 0, 0, 11, 1, 1, 1);
      @(negedge clk);
      tests++;
      if (stall !== 1'b0 || issue_fire !== 1'b0) begin
         errs++;
         $display("FAIL flush_nofire stall=%b fire=%b exp 0 0", stall, issue_fire);
      end
      next_cycle();
      drive(1, 11, 0, 0, 3'b001, 0, 0, 1, 0);
      @(negedge clk);
      tests++;
      if (stall !== 1'b0 || issue_fire !== 1'b1 || ReadData2Sel !== 2'b00) begin
         errs++;
         $display("FAIL flush_noslot stall=%b fire=%b sel2=%b exp 0 1 00", stall, issue_fire, ReadData2Sel);
      end
      next_cycle();
      drain();
      drive(1, 0, 0, 0, 0, 12, 1, 3, 0);
      next_cycle();
      drive(1, 12, 0, 0, 3'b001, 0, 0, 1, 1);
      @(negedge clk);
      tests++;
      if (stall !== 1'b1 || issue_fire !== 1'b0) begin
         errs++;
         $display("FAIL flush_stall stall=%b fire=%b exp 1 0", stall, issue_fire);
      end
      next_cycle();
      drain();
   endtask

   task automatic test_unused_self();
      drive(1, 0, 0, 0, 0, 13, 1, 4, 0);
      next_cycle();
      drive(1, 13, 14, 13, 3'b010, 14, 1, 2, 0);
      @(negedge clk);
      tests++;
      if (stall !== 1'b0 || issue_fire !== 1'b1 || ReadData1Sel !== 2'b00 ||
          ReadData2Sel !== 2'b00 || ReadDataCSel !== 2'b00) begin
         errs++;
         $display("FAIL unused_self stall=%b fire=%b sels=%b/%b/%b exp 0 1 00/00/00",
                  stall, issue_fire, ReadData1Sel, ReadData2Sel, ReadDataCSel);
      end
      next_cycle();
      drain();
   endtask

   task automatic test_full();
      int fired = 0;
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 0, 0, 0, 7'(21 + i), 1, 1, 0);
         @(negedge clk);
         if (issue_fire === 1'b1) fired++;
         next_cycle();
      end
      tests++;
      if (fired != 5) begin
         errs++; $display("FAIL full_fires got=%0d exp 5", fired);
      end
      drive(1, 21, 25, 24, 3'b111, 0, 0, 1, 0);
      @(negedge clk);
      tests++;
      if (stall !== 1'b0 || ReadData2Sel !== 2'b00 || ReadData1Sel !== 2'b01 || ReadDataCSel !== 2'b10) begin
         errs++;
         $display("FAIL full_sels stall=%b sel2=%b sel1=%b selc=%b exp 0 00 01 10",
                  stall, ReadData2Sel, ReadData1Sel, ReadDataCSel);
      end
      next_cycle();
      drain();
   endtask

   // Chain of lat-4 producers, each reading the previous one's result
   task automatic run_stalls(input int target, inout int nst, inout logic [6:0] cur_rt);
      logic f;
      int   guard = 0;
      while (nst < target && guard < 120000) begin
         @(negedge clk);
         if (stall === 1'b1) nst++;
         f = issue_fire;
         next_cycle();
         guard++;
         if (f === 1'b1) begin
            drive(1, cur_rt, 0, 0, 3'b001, (cur_rt == 7'd1) ? 7'd2 : 7'd1, 1, 4, 0);
            cur_rt = (cur_rt == 7'd1) ? 7'd2 : 7'd1;
         end
      end
      if (nst < target) begin
         errs++; $display("FAIL stall_chain_timeout got=%0d exp %0d", nst, target);
      end
   endtask

   task automatic test_counter();
`ifdef HAZARD_PERF_CNT_EN
      int nst = 0;
      logic [6:0] cur_rt = 7'd1;
      do_reset();
      drive(1, 0, 0, 0, 0, 1, 1, 4, 0);
      run_stalls(5, nst, cur_rt);
      tests++;
      if (stall_cycles !== 16'd5) begin
         errs++; $display("FAIL cnt_5 stall_cycles=%0d exp 5", stall_cycles);
      end
      run_stalls(65540, nst, cur_rt);
      tests++;
      if (stall_cycles !== 16'hFFFF) begin
         errs++; $display("FAIL cnt_sat stall_cycles=%h exp ffff", stall_cycles);
      end
      drain();
`else
      drive(1, 0, 0, 0, 0, 30, 1, 4, 0);
      next_cycle();
      drive(1, 30, 0, 0, 3'b001, 0, 0, 1, 0);
      repeat (3) next_cycle();
      tests++;
      if (stall_cycles !== 16'h0000) begin
         errs++; $display("FAIL cnt_tied stall_cycles=%h exp 0000", stall_cycles);
      end
      drain();
`endif
   endtask

   initial begin
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      test_reset();
      test_forward_l1();
      test_raw_l3();
      test_waw();
      test_lat_norm();
      test_youngest();
      test_flush();
      test_unused_self();
      test_full();
      test_reset_midop();
      test_counter();
      $display("[TB] %0d tests run, %0d failed", tests, errs);
      $finish;
   end

endmodule
